fft_out_ctrl: RTL and testbench

FFT_OUT_CTRL -- requirements
Module: fft_out_ctrl

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_reorder_buf.sv | 26 ++
 rtl/fft_out_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fft_out_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and bit-reversal helper for the FFT output controller.
package fft_pkg;

   localparam int N_FFT        = 16;
   localparam int SAMPLE_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_STREAM  = 2'd2
   } fft_state_t;

   function automatic logic [3:0] bitrev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

endpackage

// File: rtl/fft_reorder_buf.sv
// 16-entry reorder buffer: synchronous write port, asynchronous read port.
module fft_reorder_buf
   import fft_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic                clk,
   input  logic                we,
   input  logic [3:0]          waddr,
   input  logic [SAMPLE_W-1:0] wdata,
   input  logic [3:0]          raddr,
   output logic [SAMPLE_W-1:0] rdata
);

   logic [SAMPLE_W-1:0] mem_r [N_FFT];

   // Storage write; contents need no reset because every run rewrites all entries.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/fft_out_ctrl.sv
// Drains bit-reversed FFT results from two FIFOs, reorders them and streams
// bins 0..15 in natural order over a valid/ready interface.
module fft_out_ctrl
   import fft_pkg::*;
#(
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fft_done,
   input  logic                fifo1_empty,
   input  logic                fifo2_empty,
   input  logic [SAMPLE_W-1:0] fifo1_rdata,
   input  logic [SAMPLE_W-1:0] fifo2_rdata,
   output logic                fifo1_r_en,
   output logic                fifo2_r_en,
   output logic [SAMPLE_W-1:0] out_data,
   output logic [3:0]          out_index,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy,
   output logic                start_err
);

   if (FIFO_DEPTH < N_FFT / 2) begin : g_depth_check
      $error("FIFO_DEPTH cannot hold half an FFT frame");
   end

   fft_state_t          state_r, state_s;
   logic [4:0]          rd_cnt_r, cap_cnt_r;
   logic                cap_pend_r, cap_src_r;
   logic [3:0]          cap_pos_r;
   logic                cap_done_s, hs_s, rd1_s, rd2_s;
   logic [3:0]          raddr_s;
   logic [SAMPLE_W-1:0] buf_rdata_s;
   logic                out_valid_r, out_last_r, busy_r, start_err_r;
   logic [3:0]          out_index_r;
   logic [SAMPLE_W-1:0] out_data_r;
   logic                out_valid_s, out_last_s;
   logic [3:0]          out_index_s;
   logic [SAMPLE_W-1:0] out_data_s;

   assign cap_done_s = cap_pend_r && (cap_cnt_r == 5'd15);
   assign hs_s       = out_valid_r && out_ready;

   fft_reorder_buf #(.SAMPLE_W(SAMPLE_W)) u_buf (
      .clk   (clk),
      .we    (cap_pend_r),
      .waddr (bitrev4(cap_pos_r)),
      .wdata (cap_src_r ? fifo2_rdata : fifo1_rdata),
      .raddr (raddr_s),
      .rdata (buf_rdata_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; fft_done outside IDLE never restarts the sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:    state_s = fft_done ? ST_COLLECT : ST_IDLE;
         ST_COLLECT: state_s = cap_done_s ? ST_STREAM : ST_COLLECT;
         ST_STREAM:  state_s = (hs_s && (out_index_r == 4'd15)) ? ST_IDLE : ST_STREAM;
         default:    state_s = ST_IDLE;
      endcase
   end

   // Output logic: read strobes stay combinational so they can honour the current empty flags.
   always_comb begin
      rd1_s       = 1'b0;
      rd2_s       = 1'b0;
      raddr_s     = 4'd0;
      out_valid_s = out_valid_r;
      out_index_s = out_index_r;
      out_data_s  = out_data_r;
      out_last_s  = out_last_r;
      case (state_r)
         ST_IDLE: begin
            out_valid_s = 1'b0;
            out_index_s = 4'd0;
            out_data_s  = '0;
            out_last_s  = 1'b0;
         end
         ST_COLLECT: begin
            if (rd_cnt_r < 5'd8) begin
               rd1_s = !fifo1_empty;
            end else if (rd_cnt_r < 5'd16) begin
               rd2_s = !fifo2_empty;
            end else begin
               rd1_s = 1'b0;
               rd2_s = 1'b0;
            end
            out_valid_s = cap_done_s;
            out_index_s = 4'd0;
            out_data_s  = cap_done_s ? buf_rdata_s : '0;
            out_last_s  = 1'b0;
         end
         ST_STREAM: begin
            raddr_s = out_index_r + 4'd1;
            if (hs_s && (out_index_r == 4'd15)) begin
               out_valid_s = 1'b0;
               out_index_s = 4'd0;
               out_data_s  = '0;
               out_last_s  = 1'b0;
            end else if (hs_s) begin
               out_valid_s = 1'b1;
               out_index_s = raddr_s;
               out_data_s  = buf_rdata_s;
               out_last_s  = (raddr_s == 4'd15);
            end else begin
               out_valid_s = out_valid_r;
            end
         end
         default: begin
            out_valid_s = 1'b0;
            out_index_s = 4'd0;
            out_data_s  = '0;
            out_last_s  = 1'b0;
         end
      endcase
   end

   // Read/capture counters; they saturate at 16 and clear when a new run starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_r   <= 5'd0;
         cap_cnt_r  <= 5'd0;
         cap_pend_r <= 1'b0;
         cap_src_r  <= 1'b0;
         cap_pos_r  <= 4'd0;
      end else begin
         if ((state_r == ST_IDLE) && fft_done) begin
            rd_cnt_r  <= 5'd0;
            cap_cnt_r <= 5'd0;
         end else begin
            if (rd1_s || rd2_s) begin
               rd_cnt_r <= rd_cnt_r + 5'd1;
            end
            if (cap_pend_r) begin
               cap_cnt_r <= cap_cnt_r + 5'd1;
            end
         end
         cap_pend_r <= rd1_s || rd2_s;
         cap_src_r  <= rd2_s;
         cap_pos_r  <= rd_cnt_r[3:0];
      end
   end

   // Registered stream outputs, busy and sticky start error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_index_r <= 4'd0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         start_err_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_s;
         out_index_r <= out_index_s;
         out_data_r  <= out_data_s;
         out_last_r  <= out_last_s;
         busy_r      <= (state_s != ST_IDLE);
         start_err_r <= start_err_r || (fft_done && (state_r != ST_IDLE));
      end
   end

   assign fifo1_r_en = rd1_s;
   assign fifo2_r_en = rd2_s;
   assign out_data   = out_data_r;
   assign out_index  = out_index_r;
   assign out_valid  = out_valid_r;
   assign out_last   = out_last_r;
   assign busy       = busy_r;
   assign start_err  = start_err_r;

endmodule

// File: tb/tb_fft_out_ctrl.sv
// Directed self-checking bench for fft_out_ctrl with a simple two-FIFO model.
module tb_fft_out_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, fft_done, out_ready, f2_force;
   logic          fifo1_empty, fifo2_empty, fifo1_r_en, fifo2_r_en;
   logic [W-1:0]  fifo1_rdata, fifo2_rdata, out_data;
   logic [3:0]    out_index;
   logic          out_valid, out_last, busy, start_err;

   logic [W-1:0]  mem1 [0:255];
   logic [W-1:0]  mem2 [0:255];
   int            rd1 = 0, rd2 = 0, wr1 = 0, wr2 = 0;
   int            checks = 0, failures = 0;

   always #5 clk = ~clk;

   fft_out_ctrl #(.SAMPLE_W(W), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .fft_done(fft_done),
      .fifo1_empty(fifo1_empty), .fifo2_empty(fifo2_empty),
      .fifo1_rdata(fifo1_rdata), .fifo2_rdata(fifo2_rdata),
      .fifo1_r_en(fifo1_r_en), .fifo2_r_en(fifo2_r_en),
      .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .start_err(start_err)
   );

   assign fifo1_empty = (rd1 == wr1);
   assign fifo2_empty = (rd2 == wr2) || f2_force;

   // FIFO model: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (fifo1_r_en) begin
         fifo1_rdata <= mem1[rd1 % 256];
         rd1 <= rd1 + 1;
      end
      if (fifo2_r_en) begin
         fifo2_rdata <= mem2[rd2 % 256];
         rd2 <= rd2 + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] br4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   task automatic check_quiet(input string tag);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_last"},  32'(out_last),  32'd0);
      check_eq({tag, "_index"}, 32'(out_index), 32'd0);
      check_eq({tag, "_data"},  out_data,       32'd0);
      check_eq({tag, "_busy"},  32'(busy),      32'd0);
      check_eq({tag, "_ren"},   32'({fifo1_r_en, fifo2_r_en}), 32'd0);
   endtask

   // Load FIFO1 with positions 0-7 and FIFO2 with 8-15; sample = base + position.
   task automatic load(input logic [31:0] base);
      for (int p = 0; p < 8; p++) begin
         mem1[(rd1 + p) % 256] = base + 32'(p);
         mem2[(rd2 + p) % 256] = base + 32'(p + 8);
      end
      wr1 = rd1 + 8;
      wr2 = rd2 + 8;
   endtask

   task automatic do_run(input logic [31:0] base, input bit toggle_rdy, input bit f2_stall,
                         input bit dbl_done, input bit rst_mid);
      int n, reads, beats, stall_left;
      bit prev_stall, sent, f2_started, lat_chk;
      logic [31:0] pd;
      logic [3:0]  pi;
      logic        pl;
      n = 0; reads = 0; beats = 0; stall_left = 0;
      prev_stall = 0; sent = 0; f2_started = 0;
      lat_chk = !toggle_rdy && !f2_stall;
      pd = '0; pi = '0; pl = 1'b0;
      load(base);
      @(negedge clk);
      fft_done = 1'b1;
      out_ready = 1'b1;
      while (beats < 16 && n < 400) begin
         @(negedge clk);
         n++;
         fft_done = 1'b0;
         if (toggle_rdy) out_ready = ((n % 4) == 1) || ((n % 4) == 0);
         if (f2_stall && reads == 8 && !f2_started) begin
            f2_started = 1;
            stall_left = 5;
         end
         f2_force = (stall_left > 0);
         if (dbl_done && beats == 3 && !sent) begin
            fft_done = 1'b1;
            sent = 1;
         end
         if (rst_mid && reads == 10) begin
            rst = 1'b1;
            #1;
            check_quiet("rstmid");
            check_eq("rstmid_err", 32'(start_err), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (4) begin
               @(negedge clk);
               #1;
               check_eq("rstmid_noread", 32'({fifo1_r_en, fifo2_r_en}), 32'd0);
            end
            return;
         end
         #1;
         if (stall_left > 0) begin
            check_eq("f2_stall_ren", 32'(fifo2_r_en), 32'd0);
            stall_left--;
         end
         if (fifo1_r_en || fifo2_r_en) begin
            check_eq("ren_excl", 32'(fifo1_r_en && fifo2_r_en), 32'd0);
            reads++;
         end
         if (lat_chk && n == 1)  check_eq("lat_ren_first", 32'(fifo1_r_en), 32'd1);
         if (lat_chk && n == 16) check_eq("lat_ren_last", 32'(fifo2_r_en), 32'd1);
         if (lat_chk && n == 17) check_eq("lat_valid_17", 32'(out_valid), 32'd0);
         if (lat_chk && n == 18) check_eq("lat_valid_18", 32'(out_valid), 32'd1);
         if (prev_stall) begin
            check_eq("hold_data",  out_data,       pd);
            check_eq("hold_index", 32'(out_index), 32'(pi));
            check_eq("hold_last",  32'(out_last),  32'(pl));
         end
         if (out_valid && out_ready) begin
            check_eq("beat_data",  out_data, base + 32'(br4(4'(beats))));
            check_eq("beat_index", 32'(out_index), 32'(beats));
            check_eq("beat_last",  32'(out_last),  32'(beats == 15));
            beats++;
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data; pi = out_index; pl = out_last;
      end
      check_eq("run_beats", 32'(beats), 32'd16);
      check_eq("run_reads", 32'(reads), 32'd16);
      @(negedge clk);
      fft_done = 1'b0;
      f2_force = 1'b0;
      #1;
      check_quiet("after_last");
   endtask

   initial begin
      rst = 1'b1; fft_done = 1'b0; out_ready = 1'b0; f2_force = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_quiet("reset");
      check_eq("reset_err", 32'(start_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      // Idle ignores everything except fft_done.
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_quiet("idle");

      do_run(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      do_run(32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0);
      do_run(32'h0000_0200, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("err_clear", 32'(start_err), 32'd0);
      do_run(32'h0000_0300, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("err_sticky", 32'(start_err), 32'd1);
      do_run(32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b1);
      do_run(32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0);
      do_run(32'h1234_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      do_run(32'h5678_0000, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
